// File: rtl/serial_cmp_pkg.sv
// Shared types and helpers for the bit-serial magnitude comparator.
package serial_cmp_pkg;

  typedef enum logic [1:0] {IDLE, ACC, RESULT} cmp_state_t;

  // Count range 0..WIDTH+1, so WIDTH+1 is the saturation value.
  function automatic int cnt_width(input int width);
    return $clog2(width + 2);
  endfunction

endpackage

// File: rtl/serial_cmp_cell.sv
// Per-beat next-state logic for the g/l accumulators.
// SERIAL_CMP_MSB_FIRST_EN selects MSB-first order with a sticky decided flag.
module serial_cmp_cell (
  input  logic i_en,
  input  logic i_a,
  input  logic i_b,
  input  logic i_g,
  input  logic i_l,
`ifdef SERIAL_CMP_MSB_FIRST_EN
  input  logic i_dec,
  output logic o_dec,
`endif
  output logic o_g,
  output logic o_l
);

  logic w_diff;
  logic w_upd;

  assign w_diff = i_a ^ i_b;

`ifdef SERIAL_CMP_MSB_FIRST_EN
  // First differing bit is the most significant one; later ones are ignored.
  assign w_upd = i_en & w_diff & ~i_dec;
  assign o_dec = i_dec | (i_en & w_diff);
`else
  // Each later differing bit is more significant and overrides earlier ones.
  assign w_upd = i_en & w_diff;
`endif

  assign o_g = w_upd ? (i_a & ~i_b) : i_g;
  assign o_l = w_upd ? (~i_a & i_b) : i_l;

endmodule

// File: rtl/serial_comparator.sv
// Bit-serial magnitude comparator: framed bit-pair stream in, registered g/l/e/err out.
// Optional macro SERIAL_CMP_MSB_FIRST_EN switches the stream to MSB-first.
module serial_comparator
  import serial_cmp_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic a_bit,
  input  logic b_bit,
  input  logic in_last,
  output logic out_valid,
  input  logic out_ready,
  output logic g,
  output logic l,
  output logic e,
  output logic err
);

  localparam int CW = cnt_width(WIDTH);
  localparam logic [CW-1:0] CNT_W   = CW'(WIDTH);
  localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH + 1);

  cmp_state_t    r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_inc;
  logic          r_g_acc, r_l_acc, w_g_nxt, w_l_nxt;
  logic          r_g, r_l, r_e, r_err;
  logic          w_beat, w_upd, w_fin, w_clr;

  assign in_ready  = (r_state != RESULT);
  assign out_valid = (r_state == RESULT);
  assign w_beat    = in_valid & in_ready;
  assign w_upd     = w_beat & (r_cnt < CNT_W);
  assign w_fin     = w_beat & in_last;
  assign w_clr     = out_valid & out_ready;
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + CW'(1);

`ifdef SERIAL_CMP_MSB_FIRST_EN
  logic r_dec, w_dec_nxt;
`endif

  serial_cmp_cell u_cell (
    .i_en  (w_upd),
    .i_a   (a_bit),
    .i_b   (b_bit),
    .i_g   (r_g_acc),
    .i_l   (r_l_acc),
`ifdef SERIAL_CMP_MSB_FIRST_EN
    .i_dec (r_dec),
    .o_dec (w_dec_nxt),
`endif
    .o_g   (w_g_nxt),
    .o_l   (w_l_nxt)
  );

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_beat) w_state_nxt = in_last ? RESULT : ACC;
      ACC:     if (w_fin) w_state_nxt = RESULT;
      RESULT:  if (out_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_g_acc <= 1'b0;
      r_l_acc <= 1'b0;
      r_g     <= 1'b0;
      r_l     <= 1'b0;
      r_e     <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_clr) begin
        r_cnt   <= '0;
        r_g_acc <= 1'b0;
        r_l_acc <= 1'b0;
      end else if (w_beat) begin
        r_cnt   <= w_cnt_inc;
        r_g_acc <= w_g_nxt;
        r_l_acc <= w_l_nxt;
      end
      // Verdict includes the last beat's update, hence the next-state values.
      if (w_fin) begin
        r_g   <= w_g_nxt;
        r_l   <= w_l_nxt;
        r_e   <= ~w_g_nxt & ~w_l_nxt;
        r_err <= (w_cnt_inc != CNT_W);
      end
    end
  end

`ifdef SERIAL_CMP_MSB_FIRST_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_dec <= 1'b0;
    else if (w_clr)  r_dec <= 1'b0;
    else if (w_beat) r_dec <= w_dec_nxt;
  end
`endif

  assign g   = r_g;
  assign l   = r_l;
  assign e   = r_e;
  assign err = r_err;

endmodule

// File: tb/tb_serial_comparator.sv
// Self-checking bench for serial_comparator at WIDTH=4 (follows SERIAL_CMP_MSB_FIRST_EN if defined).
module tb_serial_comparator;

  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0, a_bit = 1'b0, b_bit = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic in_ready, out_valid, g, l, e, err;

  int checks = 0;
  int errs = 0;

  serial_comparator #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a_bit(a_bit), .b_bit(b_bit), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .g(g), .l(l), .e(e), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  typedef struct {
    string       name;
    int          n;
    logic [31:0] a;   // bit i is the A bit of beat i (arrival order)
    logic [31:0] b;
    logic        g, l, e, err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: operands rebuilt as integers from the first min(n,W) beats.
  task automatic model(input int n, input logic [31:0] a, input logic [31:0] b,
                       output logic mg, output logic ml, output logic me, output logic merr);
    longint va = 0, vb = 0;
    int k = (n < W) ? n : W;
    for (int i = 0; i < k; i++) begin
`ifdef SERIAL_CMP_MSB_FIRST_EN
      va = va * 2 + longint'(a[i]);
      vb = vb * 2 + longint'(b[i]);
`else
      va = va + (longint'(a[i]) << i);
      vb = vb + (longint'(b[i]) << i);
`endif
    end
    mg = va > vb;
    ml = va < vb;
    me = va == vb;
    merr = (n != W);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input string name, input int n, input logic [31:0] a,
                            input logic [31:0] b, input int gap);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      in_valid = 1'b0;
      for (int j = 0; j < gap; j++) tick();
      in_valid = 1'b1;
      a_bit = a[i];
      b_bit = b[i];
      in_last = (i == n - 1);
      while (!in_ready && t < 50) begin
        tick();
        t++;
      end
      if (t == 50) chk({name, " in_ready timeout"}, 32'd0, 32'd1);
      tick();
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic check_result(input string name, input logic xg, input logic xl,
                              input logic xe, input logic xerr);
    chk({name, " out_valid"}, {31'd0, out_valid}, 32'd1);
    chk({name, " g/l/e/err"}, {28'd0, g, l, e, err}, {28'd0, xg, xl, xe, xerr});
  endtask

  task automatic handshake(input string name, input int delay);
    logic [3:0] held;
    held = {g, l, e, err};
    out_ready = 1'b0;
    for (int j = 0; j < delay; j++) begin
      tick();
      chk({name, " stall out_valid/in_ready"}, {30'd0, out_valid, in_ready}, 32'd2);
      chk({name, " stall hold"}, {28'd0, g, l, e, err}, {28'd0, held});
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({name, " post-handshake out_valid/in_ready"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  vec_t vt[7];

  initial begin
    logic mg, ml, me, merr;

    vt[0] = '{"tp1 A1010 B0110", 4, 32'b1010, 32'b0110, 1'b1, 1'b0, 1'b0, 1'b0};
    vt[1] = '{"tp2 A=B=1101",    4, 32'b1101, 32'b1101, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[2] = '{"tp3 short 3",     3, 32'b011,  32'b001,  1'b1, 1'b0, 1'b0, 1'b1};
    vt[3] = '{"tp3 long 6",      6, 32'b110001, 32'b000010, 1'b0, 1'b1, 1'b0, 1'b1};
    vt[4] = '{"one beat",        1, 32'b1,    32'b0,    1'b1, 1'b0, 1'b0, 1'b1};
    vt[5] = '{"five beats",      5, 32'b10001, 32'b10001, 1'b0, 1'b0, 1'b1, 1'b1};
    vt[6] = '{"msb A1000 B0111", 4, 32'b0001, 32'b1110, 1'b0, 1'b1, 1'b0, 1'b0};
`ifdef SERIAL_CMP_MSB_FIRST_EN
    vt[0].g = 1'b0; vt[0].l = 1'b1;
    vt[3].g = 1'b1; vt[3].l = 1'b0;
    vt[6].g = 1'b1; vt[6].l = 1'b0;
`endif

    // Reset state
    #2;
    chk("reset out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset g/l/e/err", {28'd0, g, l, e, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-reset in_ready", {31'd0, in_ready}, 32'd1);
    tick();

    // Directed table
    for (int i = 0; i < 7; i++) begin
      send_frame(vt[i].name, vt[i].n, vt[i].a, vt[i].b, 0);
      check_result(vt[i].name, vt[i].g, vt[i].l, vt[i].e, vt[i].err);
      handshake(vt[i].name, 0);
    end

    // Backpressure: stall 3 cycles with in_valid high, then a 1-beat frame right after
    send_frame("bp", 4, 32'b1101, 32'b1101, 0);
    check_result("bp", 1'b0, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0; in_last = 1'b1;
    for (int j = 0; j < 3; j++) begin
      tick();
      chk("bp stall out_valid/in_ready", {30'd0, out_valid, in_ready}, 32'd2);
      chk("bp stall hold", {28'd0, g, l, e, err}, 32'b0010);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp handshake in_ready", {30'd0, out_valid, in_ready}, 32'd1);
    tick();
    in_valid = 1'b0; in_last = 1'b0;
    check_result("bp next beat", 1'b1, 1'b0, 1'b0, 1'b1);
    handshake("bp next", 0);

    // Async reset mid-frame (previous verdict g=1,err=1 is still in the registers)
    in_valid = 1'b1; a_bit = 1'b1; b_bit = 1'b0; in_last = 1'b0;
    tick();
    a_bit = 1'b0; b_bit = 1'b1;
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    in_valid = 1'b0;
    chk("rst mid-frame out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst mid-frame g/l/e/err", {28'd0, g, l, e, err}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("rst release in_ready", {31'd0, in_ready}, 32'd1);
    model(4, 32'b0001, 32'b0010, mg, ml, me, merr);
    send_frame("after rst", 4, 32'b0001, 32'b0010, 0);
    check_result("after rst", mg, ml, me, merr);

    // Async reset while holding a result
    #2;
    rst = 1'b1;
    #1;
    chk("rst in RESULT out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst in RESULT g/l/e/err", {28'd0, g, l, e, err}, 32'd0);
    tick();
    rst = 1'b0;
    tick();

    // Randomized frames against the reference model
    for (int r = 0; r < 60; r++) begin
      int n = $urandom_range(1, W + 3);
      logic [31:0] a = $urandom;
      logic [31:0] b = $urandom;
      if ($urandom_range(0, 3) == 0) b = a ^ (32'd1 << $urandom_range(0, W - 1));
      model(n, a, b, mg, ml, me, merr);
      send_frame("rand", n, a, b, $urandom_range(0, 1));
      check_result("rand", mg, ml, me, merr);
      handshake("rand", $urandom_range(0, 2));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
